// File: rtl/score_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : score_pkg                                                 |
// | Purpose  : Shared state encoding and default sizes for the           |
// |            high-score table controller.                              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package score_pkg;

  localparam int c_NUM_USERS = 6;
  localparam int c_SCORE_W   = 8;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_RD   = 3'd2,
    ST_WT   = 3'd3,
    ST_CMP  = 3'd4,
    ST_WR   = 3'd5,
    ST_DONE = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/score_leader_track.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : score_leader_track                                        |
// | Purpose  : Holds the overall best score and the slot that owns it.   |
// |            Ties go to the lowest slot index.                         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module score_leader_track
  import score_pkg::*;
#(
  parameter int SCORE_W = c_SCORE_W,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [ID_W-1:0]    id,
  input  logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] top_score,
  output logic [ID_W-1:0]    top_user
);

  logic [SCORE_W-1:0] r_top_score;
  logic [ID_W-1:0]    r_top_user;
  logic               w_take;

  // A new write takes the lead when it beats the leader, or ties it from a lower slot.
  assign w_take = wr_en &&
                  ((score > r_top_score) ||
                   ((score == r_top_score) && (id < r_top_user)));

  // Leader register pair; cleared on reset and during a table wipe.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      r_top_score <= '0;
      r_top_user  <= '0;
    end else if (w_take) begin
      r_top_score <= score;
      r_top_user  <= id;
    end
  end

  assign top_score = r_top_score;
  assign top_user  = r_top_user;

endmodule
`default_nettype wire

// File: rtl/score_table_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : score_table_ctrl                                          |
// | Purpose  : High-score table controller over a single-port sync RAM:  |
// |            table wipe, read-compare-write commit, register mirrors   |
// |            of every stored best and overall leader tracking.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module score_table_ctrl
  import score_pkg::*;
#(
  parameter int NUM_USERS = c_NUM_USERS,
  parameter int SCORE_W   = c_SCORE_W,
  parameter int ID_W      = 3,
  parameter int ADDR_W    = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           game_over,
  input  logic                           score_rst,
  input  logic                           clear_req,
  input  logic [ID_W-1:0]                user_id,
  input  logic [SCORE_W-1:0]             curr_score,
  output logic [ADDR_W-1:0]              ram_addr,
  output logic                           ram_wr,
  output logic [SCORE_W-1:0]             ram_din,
  input  logic [SCORE_W-1:0]             ram_dout,
  output logic [NUM_USERS*SCORE_W-1:0]   score_flat,
  output logic [SCORE_W-1:0]             top_score,
  output logic [ID_W-1:0]                top_user,
  output logic                           busy,
  output logic                           commit_done,
  output logic                           new_best
);

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUM_USERS - 1);
  localparam logic [ID_W:0]     c_ID_LIMIT  = (ID_W + 1)'(NUM_USERS);

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]  r_ram_addr, w_addr_nxt;
  logic               r_ram_wr, w_wr_nxt;
  logic [SCORE_W-1:0] r_ram_din, w_din_nxt;
  logic               r_new_best, w_nb_nxt;
  logic               r_go_prev;
  logic [ID_W-1:0]    r_id;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_mirror [NUM_USERS];
  logic               w_rise, w_latch, w_clear, w_leader_wr;
  logic [ADDR_W-1:0]  w_user_addr, w_id_addr;

  assign w_rise      = game_over & ~r_go_prev;
  assign w_user_addr = ADDR_W'(user_id);
  assign w_id_addr   = ADDR_W'(r_id);

  // Next-state and next-output decode; RAM port values are registered below.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_ram_addr;
    w_wr_nxt    = 1'b0;
    w_din_nxt   = r_ram_din;
    w_nb_nxt    = r_new_best;
    w_latch     = 1'b0;
    w_clear     = 1'b0;
    w_leader_wr = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_clear = 1'b1;
        if (r_cnt == c_LAST_ADDR) begin
          w_state_nxt = ST_IDLE;
          w_addr_nxt  = w_user_addr;
        end else begin
          w_cnt_nxt  = r_cnt + 1'b1;
          w_addr_nxt = r_cnt + 1'b1;
          w_wr_nxt   = 1'b1;
          w_din_nxt  = '0;
        end
      end
      ST_IDLE: begin
        w_addr_nxt = w_user_addr;
        if (clear_req) begin
          // A wipe request beats a simultaneous game_over rise.
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
          w_addr_nxt  = '0;
          w_wr_nxt    = 1'b1;
          w_din_nxt   = '0;
          w_clear     = 1'b1;
        end else if (w_rise && !score_rst) begin
          w_state_nxt = ST_RD;
          w_latch     = 1'b1;
          w_nb_nxt    = 1'b0;
        end
      end
      ST_RD: begin
        w_state_nxt = ST_WT;
        w_addr_nxt  = w_id_addr;
      end
      ST_WT: begin
        w_state_nxt = ST_CMP;
      end
      ST_CMP: begin
        // Out-of-range slots never write; otherwise only a strictly better score does.
        if (({1'b0, r_id} < c_ID_LIMIT) && (r_score > ram_dout)) begin
          w_state_nxt = ST_WR;
          w_wr_nxt    = 1'b1;
          w_din_nxt   = r_score;
          w_nb_nxt    = 1'b1;
        end else begin
          w_state_nxt = ST_DONE;
          w_nb_nxt    = 1'b0;
        end
      end
      ST_WR: begin
        w_state_nxt = ST_DONE;
        w_leader_wr = 1'b1;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_addr_nxt  = w_user_addr;
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
        w_addr_nxt  = '0;
        w_wr_nxt    = 1'b1;
        w_din_nxt   = '0;
      end
    endcase
  end

  // State, sweep counter, registered RAM port, commit latches and edge detector.
  always_ff @(posedge clk) begin
    r_go_prev <= game_over;
    if (!rst) begin
      r_state    <= ST_INIT;
      r_cnt      <= '0;
      r_ram_addr <= '0;
      r_ram_wr   <= 1'b1;
      r_ram_din  <= '0;
      r_new_best <= 1'b0;
      r_id       <= '0;
      r_score    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ram_addr <= w_addr_nxt;
      r_ram_wr   <= w_wr_nxt;
      r_ram_din  <= w_din_nxt;
      r_new_best <= w_nb_nxt;
      if (w_latch) begin
        r_id    <= user_id;
        r_score <= curr_score;
      end
    end
  end

  // Register mirror of the RAM table, refreshed on every committed write.
  always_ff @(posedge clk) begin
    if (!rst || w_clear) begin
      for (int k = 0; k < NUM_USERS; k++) begin
        r_mirror[k] <= '0;
      end
    end else if (w_leader_wr) begin
      r_mirror[r_id] <= r_score;
    end
  end

  generate
    for (genvar g = 0; g < NUM_USERS; g++) begin : g_flat
      assign score_flat[g*SCORE_W +: SCORE_W] = r_mirror[g];
    end
  endgenerate

  score_leader_track #(
    .SCORE_W (SCORE_W),
    .ID_W    (ID_W)
  ) u_leader (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_clear),
    .wr_en     (w_leader_wr),
    .id        (r_id),
    .score     (r_score),
    .top_score (top_score),
    .top_user  (top_user)
  );

  assign ram_addr    = r_ram_addr;
  assign ram_wr      = r_ram_wr;
  assign ram_din     = r_ram_din;
  assign busy        = (r_state != ST_IDLE);
  assign commit_done = (r_state == ST_DONE);
  assign new_best    = r_new_best;

endmodule
`default_nettype wire

// File: tb/tb_score_table_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_score_table_ctrl                                       |
// | Purpose  : Self-checking bench: sync RAM model, transaction-timeline |
// |            reference model, directed and randomized stimulus.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_score_table_ctrl;

  localparam int N  = 6;
  localparam int SW = 8;
  localparam int IW = 3;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          game_over = 1'b0;
  logic          score_rst = 1'b0;
  logic          clear_req = 1'b0;
  logic [IW-1:0] user_id = '0;
  logic [SW-1:0] curr_score = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_wr;
  logic [SW-1:0] ram_din;
  logic [SW-1:0] ram_dout;
  logic [N*SW-1:0] score_flat;
  logic [SW-1:0] top_score;
  logic [IW-1:0] top_user;
  logic          busy, commit_done, new_best;

  int n_tests = 0;
  int n_fail  = 0;

  score_table_ctrl #(.NUM_USERS(N), .SCORE_W(SW), .ID_W(IW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .game_over(game_over), .score_rst(score_rst),
    .clear_req(clear_req), .user_id(user_id), .curr_score(curr_score),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_din(ram_din), .ram_dout(ram_dout),
    .score_flat(score_flat), .top_score(top_score), .top_user(top_user),
    .busy(busy), .commit_done(commit_done), .new_best(new_best)
  );

  always #5 clk = ~clk;

  // Sync RAM: one-cycle read, write-first.
  logic [SW-1:0] mem [32];
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_din;
    ram_dout <= ram_wr ? ram_din : mem[ram_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction timeline) ----------------
  localparam int M_INIT = 0, M_IDLE = 1, M_COMMIT = 2;
  int  m_mode = M_INIT;
  int  m_k = 0;          // index of the word being wiped this cycle
  int  m_age = 0;        // cycles since the commit started (1 = first busy cycle)
  int  m_len = 0;        // cycle in which commit_done must be high
  bit  m_wr = 0;         // commit will write
  int  m_id = 0, m_sc = 0, m_idle_addr = 0;
  bit  m_prev_go = 0;
  bit  m_valid = 0;
  int  m_best [N];

  task automatic model_step();
    bit rise;
    rise = game_over && !m_prev_go;
    if (!rst) begin
      m_mode = M_INIT; m_k = 0;
      foreach (m_best[i]) m_best[i] = 0;
      m_valid = 1;
    end else begin
      case (m_mode)
        M_INIT: begin
          if (m_k == N - 1) begin m_mode = M_IDLE; m_idle_addr = int'(user_id); end
          else m_k++;
        end
        M_IDLE: begin
          m_idle_addr = int'(user_id);
          if (clear_req) begin
            m_mode = M_INIT; m_k = 0;
            foreach (m_best[i]) m_best[i] = 0;
          end else if (rise && !score_rst) begin
            m_mode = M_COMMIT; m_age = 1;
            m_id = int'(user_id); m_sc = int'(curr_score);
            m_wr = (m_id < N) && (m_sc > m_best[m_id]);
            m_len = m_wr ? 5 : 4;
          end
        end
        default: begin
          if (m_age == m_len) begin m_mode = M_IDLE; m_idle_addr = int'(user_id); end
          else begin
            m_age++;
            if (m_wr && m_age == 5) m_best[m_id] = m_sc;
          end
        end
      endcase
    end
    m_prev_go = game_over;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      logic [N*SW-1:0] ef;
      int ts, tu;
      bit ewr, edone;
      ts = 0; tu = 0;
      for (int i = 0; i < N; i++) begin
        ef[i*SW +: SW] = SW'(m_best[i]);
        if (m_best[i] > ts) begin ts = m_best[i]; tu = i; end
      end
      edone = (m_mode == M_COMMIT) && (m_age == m_len);
      ewr   = (m_mode == M_INIT) || ((m_mode == M_COMMIT) && m_wr && (m_age == 4));
      chk("busy", 64'(busy), 64'(m_mode != M_IDLE));
      chk("commit_done", 64'(commit_done), 64'(edone));
      if (edone) chk("new_best", 64'(new_best), 64'(m_wr));
      chk("ram_wr", 64'(ram_wr), 64'(ewr));
      chk("score_flat", 64'(score_flat), 64'(ef));
      chk("top_score", 64'(top_score), 64'(ts));
      chk("top_user", 64'(top_user), 64'(tu));
      if (m_mode == M_INIT) begin
        chk("init_addr", 64'(ram_addr), 64'(m_k));
        chk("init_din", 64'(ram_din), 64'd0);
      end else if (m_mode == M_IDLE) begin
        chk("idle_addr", 64'(ram_addr), 64'(m_idle_addr));
      end else if (m_age <= 2 || (m_wr && m_age == 4)) begin
        chk("commit_addr", 64'(ram_addr), 64'(m_id));
        if (m_wr && m_age == 4) chk("commit_din", 64'(ram_din), 64'(m_sc));
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic commit(input int id, input int sc, input bit srst,
                        output int lat, output bit nb, output int wrs);
    bit got;
    @(posedge clk); #2;
    user_id = IW'(id); curr_score = SW'(sc); score_rst = srst; game_over = 1'b1;
    @(posedge clk);
    lat = 0; nb = 0; wrs = 0; got = 0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      if (ram_wr) wrs++;
      if (commit_done) begin got = 1; lat = i; nb = new_best; end
    end
    @(posedge clk); #2;
    game_over = 1'b0; score_rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic check_wiped(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_flat"}, 64'(score_flat), 64'd0);
    chk({tag, "_top"}, 64'(top_score), 64'd0);
    for (int i = 0; i < N; i++) chk({tag, "_ram"}, 64'(mem[i]), 64'd0);
  endtask

  initial begin
    int lat, wrs;
    bit nb;

    // 1. reset and sweep
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("t1_sweep_wr", 64'(ram_wr), 64'd1);
      chk("t1_sweep_addr", 64'(ram_addr), 64'(i));
    end
    @(negedge clk);
    check_wiped("t1");

    // 2. first best for user 2
    commit(2, 40, 0, lat, nb, wrs);
    chk("t2_latency", 64'(lat), 64'd5);
    chk("t2_new_best", 64'(nb), 64'd1);
    chk("t2_writes", 64'(wrs), 64'd1);
    chk("t2_ram2", 64'(mem[2]), 64'd40);
    chk("t2_slot2", 64'(score_flat[2*SW +: SW]), 64'd40);
    chk("t2_top_score", 64'(top_score), 64'd40);
    chk("t2_top_user", 64'(top_user), 64'd2);

    // 3. equal and lower scores do not write
    commit(2, 40, 0, lat, nb, wrs);
    chk("t3_eq_latency", 64'(lat), 64'd4);
    chk("t3_eq_new_best", 64'(nb), 64'd0);
    chk("t3_eq_writes", 64'(wrs), 64'd0);
    commit(2, 39, 0, lat, nb, wrs);
    chk("t3_lo_latency", 64'(lat), 64'd4);
    chk("t3_lo_new_best", 64'(nb), 64'd0);
    chk("t3_lo_ram2", 64'(mem[2]), 64'd40);

    // 4. discarded score and out-of-range user
    commit(5, 30, 1, lat, nb, wrs);
    chk("t4_srst_no_done", 64'(lat), 64'd0);
    chk("t4_srst_no_write", 64'(wrs), 64'd0);
    commit(7, 99, 0, lat, nb, wrs);
    chk("t4_oor_latency", 64'(lat), 64'd4);
    chk("t4_oor_new_best", 64'(nb), 64'd0);
    chk("t4_oor_writes", 64'(wrs), 64'd0);
    chk("t4_oor_top", 64'(top_score), 64'd40);

    // 5. tie keeps lower index, higher score takes over
    commit(4, 40, 0, lat, nb, wrs);
    chk("t5_tie_new_best", 64'(nb), 64'd1);
    chk("t5_tie_top_user", 64'(top_user), 64'd2);
    commit(4, 41, 0, lat, nb, wrs);
    chk("t5_top_score", 64'(top_score), 64'd41);
    chk("t5_top_user", 64'(top_user), 64'd4);

    // 6a. reset during WR
    @(posedge clk); #2;
    user_id = 3'd3; curr_score = 8'd50; game_over = 1'b1;
    @(posedge clk);
    repeat (4) @(negedge clk);
    chk("t6_in_wr", 64'(ram_wr), 64'd1);
    rst = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1; game_over = 1'b0;
    repeat (N + 1) @(negedge clk);
    check_wiped("t6_rst");

    // 6b. clear request with scores loaded
    commit(1, 77, 0, lat, nb, wrs);
    chk("t6_ram1_loaded", 64'(mem[1]), 64'd77);
    @(posedge clk); #2 clear_req = 1'b1;
    @(posedge clk); #2 clear_req = 1'b0;
    repeat (N + 1) @(negedge clk);
    check_wiped("t6_clr");

    // Randomized traffic checked every cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 3) == 0) game_over = ~game_over;
      user_id    = IW'($urandom_range(0, 7));
      curr_score = SW'($urandom_range(0, 31));
      score_rst  = ($urandom_range(0, 4) == 0);
      clear_req  = ($urandom_range(0, 80) == 0);
      rst        = ($urandom_range(0, 200) != 0);
    end
    @(posedge clk); #2;
    rst = 1'b1; game_over = 1'b0; clear_req = 1'b0; score_rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("rand_final_idle", 64'(busy), 64'd0);
    for (int i = 0; i < N; i++) chk("rand_ram_vs_model", 64'(mem[i]), 64'(m_best[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
